// File: rtl/dmem_scan_pkg.sv
// Shared types and constants for the data-memory scan reader.
//   state_t    : fetch sequencer states
//   SEG_TABLE  : active-low {g..a} patterns for hex digits 0-F
//   WORD_BYTES : byte stride between consecutive words
package dmem_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAPT = 2'd2
  } state_t;

  localparam int unsigned WORD_BYTES = 4;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,  // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,  // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,  // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E   // C d E F
  };

endpackage

// File: rtl/hex7seg_lut.sv
// Combinational hex nibble to active-low seven-segment decoder.
//   nib   : 4-bit value to display
//   seg_c : segments {g..a}, active-low
module hex7seg_lut
  import dmem_scan_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_TABLE[nib];
  end

endmodule

// File: rtl/dmem_scan_reader.sv
// Read-side scanner for the CPU data memory: fetches one word over port B,
// holds it, and shows half of it as hex on a multiplexed 7-segment display.
// The word is re-fetched every display frame so CPU stores become visible.
//   clk, reset_n : clock, async active-low reset
//   step         : one-cycle pulse, advance word index
//   half_sel     : 0 low 4*NDIG bits, 1 next 4*NDIG bits
//   addr_b/rd_b  : dmem port B byte address / read data
//   seg, an      : segments {g..a} and digit enables, both active-low
//   word_idx     : current word index
//   busy         : fetch in progress
// Build option: define AUTO_SCAN_EN for a free-running auto-advance every
// AUTO_PERIOD cycles (an external step restarts that period).
module dmem_scan_reader
  import dmem_scan_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned NUM_WORDS   = 16,
  parameter int unsigned NDIG        = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned AUTO_PERIOD = 50_000_000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         step,
  input  logic                         half_sel,
  output logic [31:0]                  addr_b,
  input  logic [31:0]                  rd_b,
  output logic [6:0]                   seg,
  output logic [NDIG-1:0]              an,
  output logic [$clog2(NUM_WORDS)-1:0] word_idx,
  output logic                         busy
);

  localparam int unsigned IDX_W  = $clog2(NUM_WORDS);
  localparam int unsigned PTR_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned DIV_W  = $clog2(REFRESH_DIV);
  localparam int unsigned HALF_W = 4 * NDIG;

  state_t              state, state_next;
  logic                pending;
  logic [31:0]         shown;
  logic [DIV_W-1:0]    div;
  logic [PTR_W-1:0]    ptr;

  logic                step_eff_c, take_step_c, div_wrap_c, frame_wrap_c;
  logic                adv_c, capt_c, set_pend_c, clr_pend_c;
  logic [IDX_W-1:0]    idx_inc_c;
  logic [2*HALF_W-1:0] shown_ext_c;
  logic [3:0]          nib_c;
  logic [6:0]          seg_c;

  // Step source: external pulse, optionally ORed with the auto-advance tick
`ifdef AUTO_SCAN_EN
  localparam int unsigned AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  logic [AUTO_W-1:0] auto_cnt;
  logic              auto_tick_c;

  assign auto_tick_c = (auto_cnt == AUTO_W'(AUTO_PERIOD - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      auto_cnt <= '0;
    end else if (step || auto_tick_c) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + AUTO_W'(1);
    end
  end

  assign step_eff_c = step | auto_tick_c;
`else
  logic unused_auto_c;
  assign unused_auto_c = (AUTO_PERIOD == 0);
  assign step_eff_c    = step;
`endif

  assign take_step_c  = step_eff_c | pending;
  assign div_wrap_c   = (div == DIV_W'(REFRESH_DIV - 1));
  assign frame_wrap_c = div_wrap_c && (ptr == PTR_W'(NDIG - 1));
  assign idx_inc_c    = (word_idx == IDX_W'(NUM_WORDS - 1)) ? '0 : word_idx + IDX_W'(1);

  // Fetch sequencer: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Fetch sequencer: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take_step_c || frame_wrap_c) state_next = REQ;
      REQ:     state_next = CAPT;
      CAPT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Fetch sequencer: datapath controls
  always_comb begin
    adv_c      = 1'b0;
    capt_c     = 1'b0;
    set_pend_c = 1'b0;
    clr_pend_c = 1'b0;
    case (state)
      IDLE: begin
        adv_c      = take_step_c;
        clr_pend_c = pending;
      end
      REQ: begin
        set_pend_c = step_eff_c;
      end
      CAPT: begin
        set_pend_c = step_eff_c;
        capt_c     = 1'b1;
      end
      default: ;
    endcase
  end

  // Index, address, pending flag, shown word, busy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_idx <= '0;
      addr_b   <= BASE_ADDR;
      pending  <= 1'b0;
      shown    <= '0;
      busy     <= 1'b0;
    end else begin
      if (adv_c) begin
        word_idx <= idx_inc_c;
        addr_b   <= BASE_ADDR + 32'(WORD_BYTES) * 32'(idx_inc_c);
      end
      if (set_pend_c) begin
        pending <= 1'b1;
      end else if (clr_pend_c) begin
        pending <= 1'b0;
      end
      if (capt_c) begin
        shown <= rd_b;
      end
      busy <= (state_next != IDLE);
    end
  end

  // Digit scan: divider and digit pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
      ptr <= '0;
    end else if (div_wrap_c) begin
      div <= '0;
      ptr <= (ptr == PTR_W'(NDIG - 1)) ? '0 : ptr + PTR_W'(1);
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Nibble for the active digit within the selected half
  assign shown_ext_c = (2*HALF_W)'(shown);
  assign nib_c = 4'(shown_ext_c >> (HALF_W * 32'(half_sel) + 32'(ptr) * 32'd4));

  hex7seg_lut u_lut (
    .nib   (nib_c),
    .seg_c (seg_c)
  );

  // Registered display drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an  <= '1;
      seg <= 7'h7F;
    end else begin
      an  <= ~(NDIG'(1) << ptr);
      seg <= seg_c;
    end
  end

endmodule
